// File: rtl/fu_pkg.sv
// Shared definitions for the functional-unit scoreboard: FU indices,
// default per-FU latencies and stall-cause encodings.
package fu_pkg;

  localparam int FU_ALU  = 0;
  localparam int FU_MEM  = 1;
  localparam int FU_MUL  = 2;
  localparam int FU_DIV  = 3;
  localparam int FU_JUMP = 4;

  // FU 0 in the least significant byte.
  localparam logic [39:0] FU_LAT_DEF = {8'd2, 8'd24, 8'd7, 8'd2, 8'd1};

  typedef enum logic [1:0] {
    STALL_NONE   = 2'd0,
    STALL_STRUCT = 2'd1,
    STALL_RAW    = 2'd2,
    STALL_WAW    = 2'd3
  } stall_e;

endpackage

// File: rtl/fu_timer.sv
// Per-FU occupancy tracker: busy flag, latency countdown and the latched
// destination of the instruction currently held by the unit.
module fu_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] lat,
  input  logic [4:0] rd_in,
  input  logic       wb_in,
  input  logic       grant,
  output logic       busy,
  output logic       done,
  output logic       wb_req,
  output logic [4:0] rd
);

  logic       busy_r;
  logic [7:0] cnt_r;
  logic [4:0] rd_r;
  logic       wb_r;

  // Countdown is loaded with lat-1 so done rises exactly lat cycles after start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_r <= 1'b0;
      cnt_r  <= 8'd0;
      rd_r   <= 5'd0;
      wb_r   <= 1'b0;
    end else if (start) begin
      busy_r <= 1'b1;
      cnt_r  <= lat - 8'd1;
      rd_r   <= rd_in;
      wb_r   <= wb_in;
    end else if (done && (!wb_r || grant)) begin
      busy_r <= 1'b0;
    end else if (busy_r && (cnt_r != 8'd0)) begin
      cnt_r <= cnt_r - 8'd1;
    end
  end

  assign busy   = busy_r;
  assign done   = busy_r && (cnt_r == 8'd0);
  assign wb_req = done && wb_r;
  assign rd     = rd_r;

endmodule

// File: rtl/fu_scoreboard.sv
// Issue/writeback scoreboard: register result status, structural/RAW/WAW
// hazard detection and lowest-index arbitration of the single write port.
module fu_scoreboard
  import fu_pkg::*;
#(
  parameter int                  NUM_FU  = 5,
  parameter int                  FU_ID_W = 3,
  parameter logic [8*NUM_FU-1:0] FU_LAT  = FU_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  input  logic [FU_ID_W-1:0] issue_fu,
  input  logic [4:0]         issue_rd,
  input  logic [4:0]         issue_rs1,
  input  logic [4:0]         issue_rs2,
  input  logic               issue_use_rs1,
  input  logic               issue_use_rs2,
  input  logic               issue_wb,
  output logic               issue_ready,
  output logic [NUM_FU-1:0]  fu_start,
  output logic [NUM_FU-1:0]  fu_busy,
  output logic               wb_valid,
  output logic [FU_ID_W-1:0] wb_fu,
  output logic [4:0]         wb_rd,
  output logic [1:0]         stall_cause
);

  logic [31:0]        pending_r;
  logic [FU_ID_W-1:0] pend_fu_r [32];

  logic [NUM_FU-1:0]  busy_s;
  logic [NUM_FU-1:0]  done_s;
  logic [NUM_FU-1:0]  wb_req_s;
  logic [NUM_FU-1:0]  grant_s;
  logic [NUM_FU-1:0]  start_s;
  logic [NUM_FU-1:0]  cand_s;
  logic [4:0]         fu_rd_s [NUM_FU];
  logic               fu_valid_s;
  logic               sel_busy_s;
  logic               raw_s;
  logic               waw_s;
  logic               wb_dest_s;
  stall_e             stall_s;

  assign wb_dest_s = issue_wb && (issue_rd != 5'd0);

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    fu_timer u_timer (
      .clk    (clk),
      .rst    (rst),
      .start  (start_s[g]),
      .lat    (FU_LAT[8*g +: 8]),
      .rd_in  (issue_rd),
      .wb_in  (wb_dest_s),
      .grant  (grant_s[g]),
      .busy   (busy_s[g]),
      .done   (done_s[g]),
      .wb_req (wb_req_s[g]),
      .rd     (fu_rd_s[g])
    );
  end

  // Hazard detection and issue decision from registered state only.
  always_comb begin
    fu_valid_s = 1'b0;
    sel_busy_s = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (issue_fu == FU_ID_W'(i)) begin
        fu_valid_s = 1'b1;
        sel_busy_s = busy_s[i];
      end else begin
        sel_busy_s = sel_busy_s;
      end
    end
    raw_s = (issue_use_rs1 && (issue_rs1 != 5'd0) && pending_r[issue_rs1]) ||
            (issue_use_rs2 && (issue_rs2 != 5'd0) && pending_r[issue_rs2]);
    waw_s = wb_dest_s && pending_r[issue_rd];
    if (!rst || !issue_valid) begin
      stall_s = STALL_NONE;
    end else if (!fu_valid_s || sel_busy_s) begin
      stall_s = STALL_STRUCT;
    end else if (raw_s) begin
      stall_s = STALL_RAW;
    end else if (waw_s) begin
      stall_s = STALL_WAW;
    end else begin
      stall_s = STALL_NONE;
    end
    issue_ready = rst && issue_valid && (stall_s == STALL_NONE);
    for (int i = 0; i < NUM_FU; i++) begin
      start_s[i] = issue_ready && (issue_fu == FU_ID_W'(i));
    end
  end

  // Lowest-index done unit with a pending write owns the register-file port.
  always_comb begin
    cand_s   = rst ? (done_s & wb_req_s) : '0;
    grant_s  = '0;
    wb_valid = 1'b0;
    wb_fu    = '0;
    wb_rd    = 5'd0;
    for (int i = 0; i < NUM_FU; i++) begin
      grant_s[i] = cand_s[i] && !wb_valid;
      wb_fu      = grant_s[i] ? FU_ID_W'(i) : wb_fu;
      wb_rd      = grant_s[i] ? fu_rd_s[i]  : wb_rd;
      wb_valid   = wb_valid | grant_s[i];
    end
  end

  // Register result status: cleared on write-back, set on issue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_r <= 32'd0;
      pend_fu_r <= '{default: '0};
    end else begin
      if (wb_valid && (pend_fu_r[wb_rd] == wb_fu)) begin
        pending_r[wb_rd] <= 1'b0;
      end
      if (issue_ready && wb_dest_s) begin
        pending_r[issue_rd] <= 1'b1;
        pend_fu_r[issue_rd] <= issue_fu;
      end
    end
  end

  assign fu_start    = start_s;
  assign fu_busy     = busy_s;
  assign stall_cause = stall_s;

endmodule

// File: tb/tb_fu_scoreboard.sv
// Directed and randomized bench for fu_scoreboard, checked every cycle against
// a timestamp-based model of FU occupancy and register result status.
module tb_fu_scoreboard;

  localparam int NFU = 5;
  localparam int LAT [NFU] = '{1, 2, 7, 24, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       issue_valid = 1'b0;
  logic [2:0] issue_fu = 3'd0;
  logic [4:0] issue_rd = 5'd0;
  logic [4:0] issue_rs1 = 5'd0;
  logic [4:0] issue_rs2 = 5'd0;
  logic       issue_use_rs1 = 1'b0;
  logic       issue_use_rs2 = 1'b0;
  logic       issue_wb = 1'b0;
  logic       issue_ready;
  logic [4:0] fu_start;
  logic [4:0] fu_busy;
  logic       wb_valid;
  logic [2:0] wb_fu;
  logic [4:0] wb_rd;
  logic [1:0] stall_cause;

  always #5 clk = ~clk;

  fu_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_fu      (issue_fu),
    .issue_rd      (issue_rd),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_use_rs1 (issue_use_rs1),
    .issue_use_rs2 (issue_use_rs2),
    .issue_wb      (issue_wb),
    .issue_ready   (issue_ready),
    .fu_start      (fu_start),
    .fu_busy       (fu_busy),
    .wb_valid      (wb_valid),
    .wb_fu         (wb_fu),
    .wb_rd         (wb_rd),
    .stall_cause   (stall_cause)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: each FU holds an instruction whose result becomes available at m_fin.
  bit         m_busy [NFU];
  int         m_fin  [NFU];
  logic [4:0] m_rd   [NFU];
  bit         m_wb   [NFU];
  bit         m_pend [32];
  bit         s_ready;
  int         s_win;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic present(input int v, input int f, input int rd, input int rs1,
                         input int rs2, input int u1, input int u2, input int wb);
    issue_valid   = (v != 0);
    issue_fu      = 3'(f);
    issue_rd      = 5'(rd);
    issue_rs1     = 5'(rs1);
    issue_rs2     = 5'(rs2);
    issue_use_rs1 = (u1 != 0);
    issue_use_rs2 = (u2 != 0);
    issue_wb      = (wb != 0);
  endtask

  task automatic idle();
    present(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sample();
    int         f;
    bit         st, raw, waw;
    logic [1:0] es;
    logic [4:0] estart, ebusy, erd;
    @(negedge clk);
    s_win = -1;
    if (rst) begin
      for (int i = NFU - 1; i >= 0; i--)
        if (m_busy[i] && cyc >= m_fin[i] && m_wb[i]) s_win = i;
    end
    f  = int'(issue_fu);
    st = 1'b1;
    if (f < NFU) st = m_busy[f];
    raw = (issue_use_rs1 && issue_rs1 != 5'd0 && m_pend[issue_rs1]) ||
          (issue_use_rs2 && issue_rs2 != 5'd0 && m_pend[issue_rs2]);
    waw = issue_wb && issue_rd != 5'd0 && m_pend[issue_rd];
    es = 2'd0;
    if (rst && issue_valid) es = st ? 2'd1 : raw ? 2'd2 : waw ? 2'd3 : 2'd0;
    s_ready = rst && issue_valid && es == 2'd0;
    estart  = s_ready ? (5'd1 << f) : 5'd0;
    for (int i = 0; i < NFU; i++) ebusy[i] = m_busy[i];
    erd = (s_win >= 0) ? m_rd[s_win] : 5'd0;
    chk("ready", 32'(issue_ready), 32'(s_ready));
    chk("stall", 32'(stall_cause), 32'(es));
    chk("start", 32'(fu_start), 32'(estart));
    chk("busy", 32'(fu_busy), 32'(ebusy));
    chk("wb_valid", 32'(wb_valid), 32'(s_win >= 0));
    chk("wb_fu", 32'(wb_fu), (s_win >= 0) ? 32'(s_win) : 32'd0);
    chk("wb_rd", 32'(wb_rd), 32'(erd));
  endtask

  task automatic advance();
    int f;
    if (!rst) begin
      for (int i = 0; i < NFU; i++) m_busy[i] = 1'b0;
      for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    end else begin
      if (s_win >= 0) begin
        m_busy[s_win] = 1'b0;
        m_pend[m_rd[s_win]] = 1'b0;
      end
      for (int i = 0; i < NFU; i++)
        if (m_busy[i] && cyc >= m_fin[i] && !m_wb[i]) m_busy[i] = 1'b0;
      if (s_ready) begin
        f = int'(issue_fu);
        m_busy[f] = 1'b1;
        m_fin[f]  = cyc + LAT[f];
        m_rd[f]   = issue_rd;
        m_wb[f]   = issue_wb && issue_rd != 5'd0;
        if (m_wb[f]) m_pend[issue_rd] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_idle(input int n);
    idle();
    for (int k = 0; k < n; k++) begin
      sample();
      advance();
    end
  endtask

  initial begin
    int divwb;
    for (int i = 0; i < NFU; i++) begin
      m_busy[i] = 1'b0; m_fin[i] = 0; m_rd[i] = 5'd0; m_wb[i] = 1'b0;
    end
    for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;

    // Reset with a valid request present
    rst = 1'b0;
    present(1, 0, 5, 0, 0, 0, 0, 1);
    sample(); advance();
    sample();
    chk("rst_ready", 32'(issue_ready), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    advance();
    rst = 1'b1;

    // ALU x5, latency 1
    present(1, 0, 5, 0, 0, 0, 0, 1);
    sample(); chk("alu_start", 32'(fu_start), 32'h1); advance();
    idle();
    sample();
    chk("alu_wb_valid", 32'(wb_valid), 32'd1);
    chk("alu_wb_fu", 32'(wb_fu), 32'd0);
    chk("alu_wb_rd", 32'(wb_rd), 32'd5);
    advance();
    sample(); chk("alu_busy_clr", 32'(fu_busy[0]), 32'd0); advance();

    // DIV x6 then dependent add x7,x6,x1
    present(1, 3, 6, 0, 0, 0, 0, 1);
    sample(); advance();
    present(1, 0, 7, 6, 1, 1, 1, 1);
    for (int k = 1; k <= 24; k++) begin
      sample(); chk("raw_stall", 32'(stall_cause), 32'd2); advance();
    end
    sample(); chk("raw_release", 32'(issue_ready), 32'd1); advance();
    run_idle(3);

    // MUL x8 then MUL x9: structural
    present(1, 2, 8, 0, 0, 0, 0, 1);
    sample(); advance();
    present(1, 2, 9, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 7; k++) begin
      sample(); chk("struct_stall", 32'(stall_cause), 32'd1); advance();
    end
    sample(); chk("struct_release", 32'(issue_ready), 32'd1); advance();
    run_idle(10);

    // MEM x11 at T, ALU x12 at T+1: both done at T+2
    present(1, 1, 11, 0, 0, 0, 0, 1);
    sample(); advance();
    present(1, 0, 12, 0, 0, 0, 0, 1);
    sample(); advance();
    idle();
    sample();
    chk("arb_win_fu", 32'(wb_fu), 32'd0);
    chk("arb_win_rd", 32'(wb_rd), 32'd12);
    chk("arb_mem_held", 32'(fu_busy[1]), 32'd1);
    advance();
    sample();
    chk("arb_lose_valid", 32'(wb_valid), 32'd1);
    chk("arb_lose_fu", 32'(wb_fu), 32'd1);
    chk("arb_lose_rd", 32'(wb_rd), 32'd11);
    advance();
    sample(); chk("arb_mem_clr", 32'(fu_busy[1]), 32'd0); advance();

    // WAW: MUL x10 in flight, ALU x10 presented
    present(1, 2, 10, 0, 0, 0, 0, 1);
    sample(); advance();
    present(1, 0, 10, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 7; k++) begin
      sample(); chk("waw_stall", 32'(stall_cause), 32'd3); advance();
    end
    sample(); chk("waw_release", 32'(issue_ready), 32'd1); advance();
    run_idle(3);

    // Write to x0 never sets pending or writes back
    present(1, 0, 0, 0, 0, 0, 0, 1);
    sample(); advance();
    present(1, 4, 3, 0, 0, 1, 1, 1);
    sample();
    chk("x0_no_wb", 32'(wb_valid), 32'd0);
    chk("x0_no_raw", 32'(issue_ready), 32'd1);
    advance();
    run_idle(4);

    // Reset in the middle of a DIV
    present(1, 3, 13, 0, 0, 0, 0, 1);
    sample(); advance();
    run_idle(5);
    rst = 1'b0;
    sample(); advance();
    rst = 1'b1;
    present(1, 0, 14, 13, 0, 1, 0, 1);
    sample();
    chk("rst_busy_clr", 32'(fu_busy), 32'd0);
    chk("rst_issue_now", 32'(issue_ready), 32'd1);
    advance();
    idle();
    divwb = 0;
    for (int k = 0; k < 30; k++) begin
      sample();
      if (wb_valid && wb_fu == 3'd3) divwb++;
      advance();
    end
    chk("rst_div_dropped", 32'(divwb), 32'd0);

    // Randomized traffic with a small register set to provoke hazards
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 149) != 0);
      present(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 5)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 3) != 0));
      sample(); advance();
    end
    rst = 1'b1;
    run_idle(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
